wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and register file for the five-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs, latches them into an internal MEM/WB register, and commits them to a 32-entry register file one cycle later. Serves the ID stage's two combinational read ports, with full forwarding from both the EX/MEM and MEM/WB stages so back-to-back dependent R-type instructions need no stall.

## Interface
Parameters:
- DATA_W, 32, register and result width
- ADDR_W, 5, register address width (2**ADDR_W entries)
- CNT_W, 32, retire counter width (used only with WB_RETIRE_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- RegWrite_in  in  1  EX/MEM write-enable
- RdAddr_in  in  ADDR_W  EX/MEM destination register
- ALU_result_in  in  DATA_W  EX/MEM result
- flush_in  in  1  kill the EX/MEM entry being captured this edge
- RsAddr  in  ADDR_W  read port A address
- RtAddr  in  ADDR_W  read port B address
- RsData  out  DATA_W  read port A data (combinational)
- RtData  out  DATA_W  read port B data (combinational)
- WbRegWrite  out  1  MEM/WB write-enable (registered)
- WbRdAddr  out  ADDR_W  MEM/WB destination (registered)
- WbData  out  DATA_W  MEM/WB data (registered)
- retire_count  out  CNT_W  committed-write count (only with WB_RETIRE_CNT_EN)

## Operation
- Capture: every rising edge, MEM/WB <= {RegWrite_in & ~flush_in, RdAddr_in, ALU_result_in}. No hold/stall input; the register updates every cycle.
- Commit: every rising edge, if WbRegWrite=1 and WbRdAddr!=0, array[WbRdAddr] <= WbData. Commit and capture occur on the same edge (commit uses pre-edge MEM/WB contents).
- Register 0 is hardwired zero: never written, always reads 0, never forwarded.
- Read priority per port (addr != 0):
  1. RegWrite_in=1, flush_in=0, RdAddr_in==addr -> ALU_result_in
  2. else WbRegWrite=1, WbRdAddr==addr -> WbData
  3. else array[addr]
- Both ports resolve independently; RsAddr==RtAddr returns identical data.
- flush_in=1 with RegWrite_in=1: entry neither forwarded nor captured as a write; address/data still latch into WbRdAddr/WbData (don't-care with WbRegWrite=0).
- Reset: WbRegWrite=0, WbRdAddr=0, WbData=0, all 2**ADDR_W array entries=0, retire_count=0. rst overrides capture and commit on the same edge; a write pending in MEM/WB at reset is dropped.
- Reads during rst=1 follow the normal combinational path from current state.

## Timing
- EX/MEM value at edge N appears on WbData after edge N; lands in array at edge N+1.
- Forwarding latency 0: a read in the same cycle as the EX/MEM value returns it.
- Value readable through every path from the EX/MEM cycle onward with no gap: EX/MEM bypass (cycle N), MEM/WB bypass (cycle N+1), array (cycle N+2 onward).
- Two consecutive writes to the same register: younger (EX/MEM) wins on reads; array ends holding the younger value.

## Configuration
- WB_RETIRE_CNT_EN defined: retire_count port and CNT_W-bit counter present; increments by 1 on each edge where WbRegWrite=1 (including WbRdAddr=0), saturates at all-ones, cleared by rst.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared pipeline package: DATA_W/ADDR_W defaults, REG_ZERO constant, mem_wb_t struct {we, rd, data}.
- One sub-module: wb_fwd_mux (combinational three-level priority select), instantiated once per read port.
- Array, MEM/WB register and counter live in wb_regfile.

## Test plan
- Reset: preload writes, assert rst one cycle -> all Wb* outputs 0, reads of r1..r31 return 0, retire_count=0.
- Write r5=0xDEADBEEF, then idle -> RsAddr=5 returns 0xDEADBEEF in cycles N, N+1, N+2 (EX/MEM, MEM/WB, array paths).
- Back-to-back r3=0x11 then r3=0x22 -> read returns 0x11 in first cycle, 0x22 from second onward; array holds 0x22.
- Write r0=0xFFFFFFFF -> reads of r0 return 0 in all cycles; retire_count increments by 1.
- flush_in=1 with write r7=0x55 (r7 previously 0x10) -> r7 reads 0x10 throughout; WbRegWrite=0; no count.
- rst asserted while MEM/WB holds write r9=0x99 -> r9 reads 0 after reset; no commit.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage and register file.
// Holds the default widths, the hardwired-zero register index and the
// MEM/WB pipeline register layout used by neighbouring pipeline stages.
package wb_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Register 0 reads as zero, is never written and is never forwarded.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    // MEM/WB pipeline register contents at the default widths.
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } mem_wb_t;

endpackage

// File: rtl/wb_fwd_mux.sv
// Forwarding select for one register read port.
// Priority: EX/MEM result, then MEM/WB result, then the register array.
// Address 0 always returns zero regardless of any pending write to it.
module wb_fwd_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data
);

    // Youngest matching producer wins; ex_we already excludes flushed entries.
    always_comb begin
        data = rf_data;
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end else if (ex_we && (ex_rd == addr)) begin
            data = ex_data;
        end else if (wb_we && (wb_rd == addr)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 2**ADDR_W-entry register file for the five-stage
// pipeline. EX/MEM results are captured into the MEM/WB register every
// edge and committed to the array one edge later; both read ports forward
// from EX/MEM and MEM/WB so dependent back-to-back instructions need no stall.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire_count port and a
// saturating count of committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
`ifdef WB_RETIRE_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic [ADDR_W-1:0] RdAddr_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic              flush_in,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    output logic              WbRegWrite,
    output logic [ADDR_W-1:0] WbRdAddr,
    output logic [DATA_W-1:0] WbData
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_count
`endif
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              ex_we;

    // A flushed EX/MEM entry is neither forwarded nor captured as a write.
    assign ex_we = RegWrite_in & ~flush_in;

    // MEM/WB capture: updates every edge, no stall; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            WbRegWrite <= 1'b0;
            WbRdAddr   <= '0;
            WbData     <= '0;
        end else begin
            WbRegWrite <= ex_we;
            WbRdAddr   <= RdAddr_in;
            WbData     <= ALU_result_in;
        end
    end

    // Commit from the pre-edge MEM/WB contents; register 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WbRegWrite && (WbRdAddr != ADDR_W'(REG_ZERO))) begin
            regs[WbRdAddr] <= WbData;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Count every committed write (including to register 0), saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= '0;
        end else if (WbRegWrite && (retire_count != {CNT_W{1'b1}})) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end
`endif

    wb_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_rs (
        .addr    (RsAddr),
        .ex_we   (ex_we),
        .ex_rd   (RdAddr_in),
        .ex_data (ALU_result_in),
        .wb_we   (WbRegWrite),
        .wb_rd   (WbRdAddr),
        .wb_data (WbData),
        .rf_data (regs[RsAddr]),
        .data    (RsData)
    );

    wb_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_rt (
        .addr    (RtAddr),
        .ex_we   (ex_we),
        .ex_rd   (RdAddr_in),
        .ex_data (ALU_result_in),
        .wb_we   (WbRegWrite),
        .wb_rd   (WbRdAddr),
        .wb_data (WbData),
        .rf_data (regs[RtAddr]),
        .data    (RtData)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Build with
// WB_RETIRE_CNT_EN defined to also check the retire counter.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          RegWrite_in;
    logic [AW-1:0] RdAddr_in;
    logic [DW-1:0] ALU_result_in;
    logic          flush_in;
    logic [AW-1:0] RsAddr;
    logic [AW-1:0] RtAddr;
    logic [DW-1:0] RsData;
    logic [DW-1:0] RtData;
    logic          WbRegWrite;
    logic [AW-1:0] WbRdAddr;
    logic [DW-1:0] WbData;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]   retire_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q[$];

    // Reference state: register contents, MEM/WB stage and retire count.
    logic [DW-1:0] m_regs [32];
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic [31:0]   m_cnt;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite_in   (RegWrite_in),
        .RdAddr_in     (RdAddr_in),
        .ALU_result_in (ALU_result_in),
        .flush_in      (flush_in),
        .RsAddr        (RsAddr),
        .RtAddr        (RtAddr),
        .RsData        (RsData),
        .RtData        (RtData),
        .WbRegWrite    (WbRegWrite),
        .WbRdAddr      (WbRdAddr),
        .WbData        (WbData)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    // Clock and initial input values.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1;
        RegWrite_in = 1'b0;
        RdAddr_in = '0;
        ALU_result_in = '0;
        flush_in = 1'b0;
        RsAddr = '0;
        RtAddr = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_we = 1'b0;
        m_rd = '0;
        m_data = '0;
        m_cnt = '0;
    end

    // Advance one edge (updating the reference from the inputs held across
    // that edge), then apply the next cycle's inputs.
    task automatic drive(input logic r, input logic we, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d, input logic fl,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_we = 1'b0;
            m_rd = '0;
            m_data = '0;
            m_cnt = '0;
        end else begin
            if (m_we && m_rd != 0) m_regs[m_rd] = m_data;
            if (m_we && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_we = RegWrite_in & ~flush_in;
            m_rd = RdAddr_in;
            m_data = ALU_result_in;
        end
        #1;
        rst = r;
        RegWrite_in = we;
        RdAddr_in = rd;
        ALU_result_in = d;
        flush_in = fl;
        RsAddr = rs;
        RtAddr = rt;
    endtask

    // Expected read result for the currently applied inputs.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (RegWrite_in && !flush_in && RdAddr_in == a) return ALU_result_in;
        if (m_we && m_rd == a) return m_data;
        return m_regs[a];
    endfunction

    task automatic test_reset();
        logic [DW-1:0] e;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5'd1, 32'h0000_000A, 0, 0, 0);
        drive(0, 1, 5'd2, 32'h0000_000B, 0, 0, 0);
        drive(0, 1, 5'd31, 32'h0000_000C, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        // Reset cycle with a live write on the inputs: the capture must lose.
        drive(1, 1, 5'd1, 32'h0000_0077, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'd1, 5'd31);
        @(negedge clk);
        tests_run++;
        if (WbRegWrite !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wb_we got=%0b exp=0", WbRegWrite);
        end
        tests_run++;
        if (WbRdAddr !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_wb_rd got=%0d exp=0", WbRdAddr);
        end
        tests_run++;
        if (WbData !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_wb_data got=%h exp=0", WbData);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (retire_count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_count got=%0d exp=0", retire_count);
        end
`endif
        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 5'(i), 5'(32 - i));
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL reset_read_rs r%0d got=%h exp=%h", i, RsData, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (RtData !== e) begin
                tests_failed++;
                $display("FAIL reset_read_rt r%0d got=%h exp=%h", 32 - i, RtData, e);
            end
        end
    endtask

    task automatic test_fwd_paths();
        logic [DW-1:0] e;
        // Cycle N (EX/MEM bypass), N+1 (MEM/WB bypass), N+2 and N+3 (array).
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd5, 5'd5);
            else        drive(0, 0, 5'd0, 32'h0, 0, 5'd5, 5'd5);
            exp_q.push_back(32'hDEAD_BEEF);
            exp_q.push_back(32'hDEAD_BEEF);
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL fwd_rs cycle=%0d got=%h exp=%h", c, RsData, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (RtData !== e) begin
                tests_failed++;
                $display("FAIL fwd_rt cycle=%0d got=%h exp=%h", c, RtData, e);
            end
            if (c == 1) begin
                tests_run++;
                if (WbRegWrite !== 1'b1 || WbRdAddr !== 5'd5 || WbData !== 32'hDEAD_BEEF) begin
                    tests_failed++;
                    $display("FAIL fwd_memwb got=%0b/%0d/%h exp=1/5/deadbeef",
                             WbRegWrite, WbRdAddr, WbData);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        logic [DW-1:0] exp_tbl [5] = '{32'h11, 32'h22, 32'h22, 32'h22, 32'h22};
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      drive(0, 1, 5'd3, 32'h11, 0, 5'd3, 5'd3);
            else if (c == 1) drive(0, 1, 5'd3, 32'h22, 0, 5'd3, 5'd3);
            else             drive(0, 0, 5'd0, 32'h0, 0, 5'd3, 5'd0);
            exp_q.push_back(exp_tbl[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL b2b_r3 cycle=%0d got=%h exp=%h", c, RsData, e);
            end
        end
    endtask

    task automatic test_reg_zero();
        logic [DW-1:0] e;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0);
            else        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL r0_rs cycle=%0d got=%h exp=%h", c, RsData, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (RtData !== e) begin
                tests_failed++;
                $display("FAIL r0_rt cycle=%0d got=%h exp=%h", c, RtData, e);
            end
            if (c == 1) begin
                tests_run++;
                if (WbRegWrite !== 1'b1 || WbRdAddr !== 5'd0) begin
                    tests_failed++;
                    $display("FAIL r0_memwb got=%0b/%0d exp=1/0", WbRegWrite, WbRdAddr);
                end
            end
        end
`ifdef WB_RETIRE_CNT_EN
        // Writes so far since reset: r5, r3 twice, r0.
        tests_run++;
        if (retire_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL r0_count got=%0d exp=4", retire_count);
        end
`endif
    endtask

    task automatic test_flush();
        logic [DW-1:0] e;
        drive(0, 1, 5'd7, 32'h10, 0, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(0, 1, 5'd7, 32'h55, 1, 5'd7, 5'd7);
            else        drive(0, 0, 5'd0, 32'h0, 0, 5'd7, 5'd7);
            exp_q.push_back(32'h10);
            exp_q.push_back(32'h10);
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL flush_rs cycle=%0d got=%h exp=%h", c, RsData, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (RtData !== e) begin
                tests_failed++;
                $display("FAIL flush_rt cycle=%0d got=%h exp=%h", c, RtData, e);
            end
            if (c == 1) begin
                tests_run++;
                if (WbRegWrite !== 1'b0 || WbRdAddr !== 5'd7) begin
                    tests_failed++;
                    $display("FAIL flush_memwb got=%0b/%0d exp=0/7", WbRegWrite, WbRdAddr);
                end
            end
        end
`ifdef WB_RETIRE_CNT_EN
        // Only the r7=0x10 write adds to the previous 4.
        tests_run++;
        if (retire_count !== 32'd5) begin
            tests_failed++;
            $display("FAIL flush_count got=%0d exp=5", retire_count);
        end
`endif
    endtask

    task automatic test_rst_drop();
        logic [DW-1:0] e;
        logic [DW-1:0] exp_tbl [4] = '{32'h99, 32'h99, 32'h0, 32'h0};
        for (int c = 0; c < 4; c++) begin
            if (c == 0)      drive(0, 1, 5'd9, 32'h99, 0, 5'd9, 5'd9);
            else if (c == 1) drive(1, 0, 5'd0, 32'h0, 0, 5'd9, 5'd9);
            else             drive(0, 0, 5'd0, 32'h0, 0, 5'd9, 5'd9);
            exp_q.push_back(exp_tbl[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL rstdrop_r9 cycle=%0d got=%h exp=%h", c, RsData, e);
            end
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (retire_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstdrop_count got=%0d exp=0", retire_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        for (int c = 0; c < 300; c++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), $urandom(), ($urandom_range(0, 7) == 0), rs, rt);
            exp_q.push_back(model_read(rs));
            exp_q.push_back(model_read(rt));
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if (RsData !== e) begin
                tests_failed++;
                $display("FAIL rand_rs cycle=%0d r%0d got=%h exp=%h", c, rs, RsData, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (RtData !== e) begin
                tests_failed++;
                $display("FAIL rand_rt cycle=%0d r%0d got=%h exp=%h", c, rt, RtData, e);
            end
        end
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        @(negedge clk);
        tests_run++;
        if (WbRegWrite !== m_we || WbRdAddr !== m_rd || WbData !== m_data) begin
            tests_failed++;
            $display("FAIL rand_memwb got=%0b/%0d/%h exp=%0b/%0d/%h",
                     WbRegWrite, WbRdAddr, WbData, m_we, m_rd, m_data);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (retire_count !== m_cnt) begin
            tests_failed++;
            $display("FAIL rand_count got=%0d exp=%0d", retire_count, m_cnt);
        end
`endif
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_fwd_paths();
        test_back_to_back();
        test_reg_zero();
        test_flush();
        test_rst_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
